// File: rtl/atax_pkg.sv
// rtl/atax_pkg.sv - shared types, defaults and width helper for the atax argument memory
//
// Purpose : FSM state encoding, default bus geometry and a ceil-log2 helper
//           used to size word-index and byte-offset fields.
// Ports   : none (package).

package atax_pkg;

    localparam int ATAX_BUS_SIZE    = 64;
    localparam int ATAX_BUS_BYTES   = ATAX_BUS_SIZE / 8;
    localparam int ATAX_ADDR_W      = 32;
    localparam int ATAX_DEPTH       = 256;
    localparam int ATAX_WAIT_CYCLES = 1;
    localparam int ATAX_CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } atax_state_e;

    // Smallest w with 2**w >= value; returns 0 for value <= 1.
    function automatic int atax_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/atax_be_ram.sv
// rtl/atax_be_ram.sv - single-clock dual-port RAM, byte-enabled port A, full-word port B
//
// Purpose : backing store for one accelerator array argument.
// Ports   : clk_i/reset_i   clock, synchronous active-high reset (output regs only)
//           a_en_i          port A read enable (registered read)
//           a_we_i/a_be_i   port A write strobe and byte lanes
//           a_addr_i        port A word index
//           a_wdata_i       port A write data
//           a_rdata_o       port A registered read data
//           b_we_i          port B full-word write strobe
//           b_addr_i        port B word index (read every cycle)
//           b_wdata_i       port B write data
//           b_rdata_o       port B registered read data, write-first

module atax_be_ram
    import atax_pkg::*;
#(
    parameter int DATA_W = ATAX_BUS_SIZE,
    parameter int BYTES  = DATA_W / 8,
    parameter int DEPTH  = ATAX_DEPTH,
    localparam int AW    = atax_clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              a_en_i,
    input  logic              a_we_i,
    input  logic [BYTES-1:0]  a_be_i,
    input  logic [AW-1:0]     a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic [DATA_W-1:0] a_rdata_o,
    input  logic              b_we_i,
    input  logic [AW-1:0]     b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic [DATA_W-1:0] b_rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            for (int b = 0; b < BYTES; b++) begin
                if (a_be_i[b]) begin
                    mem_q[a_addr_i][b*8 +: 8] <= a_wdata_i[b*8 +: 8];
                end
            end
        end
        // Port B is written after port A so that, on a same-word collision,
        // its later non-blocking update overrides every lane: load wins.
        if (b_we_i) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_en_i) begin
                // A simultaneous load to the same word is returned, not the old data.
                a_rdata_q <= (b_we_i && (b_addr_i == a_addr_i)) ? b_wdata_i : mem_q[a_addr_i];
            end
            b_rdata_q <= b_we_i ? b_wdata_i : mem_q[b_addr_i];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/atax_arg_mem.sv
// rtl/atax_arg_mem.sv - Avalon-MM slave argument memory with fixed wait-states and load/dump port
//
// Purpose : serves one array argument (A, x or y) of the atax accelerator.
//           Every transfer takes WAIT_CYCLES + 2 cycles; a side port preloads
//           and dumps words while the accelerator is idle.
// Ports   : clk, reset            clock, synchronous active-high reset
//           avs_read/avs_write    requests, held until accepted
//           avs_address           byte address
//           avs_writedata         write data
//           avs_byteenable        write byte lanes
//           avs_readdata          read data, valid in the acceptance cycle
//           avs_waitrequest       stall, low in the acceptance cycle
//           ld_en/ld_addr/ld_data side-port full-word write
//           dump_data             registered mem[ld_addr], 1-cycle latency
//           err                   sticky protocol/range error

module atax_arg_mem
    import atax_pkg::*;
#(
    parameter int BUS_SIZE    = ATAX_BUS_SIZE,
    parameter int BUS_BYTES   = BUS_SIZE / 8,
    parameter int ADDR_W      = ATAX_ADDR_W,
    parameter int DEPTH       = ATAX_DEPTH,
    parameter int WAIT_CYCLES = ATAX_WAIT_CYCLES,
    localparam int IDX_W      = atax_clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic [BUS_SIZE-1:0]  avs_writedata,
    input  logic [BUS_BYTES-1:0] avs_byteenable,
    output logic [BUS_SIZE-1:0]  avs_readdata,
    output logic                 avs_waitrequest,
    input  logic                 ld_en,
    input  logic [IDX_W-1:0]     ld_addr,
    input  logic [BUS_SIZE-1:0]  ld_data,
    output logic [BUS_SIZE-1:0]  dump_data,
    output logic                 err
);

    localparam int OFF_W   = atax_clog2(BUS_BYTES);
    localparam int TOP_LSB = OFF_W + IDX_W;
    localparam logic [ATAX_CNT_W-1:0] CNT_LOAD =
        ATAX_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    atax_state_e           state_q;
    logic [ATAX_CNT_W-1:0] cnt_q;
    logic                  err_q;
    logic                  rd_zero_q;

    logic                  req;
    logic [IDX_W-1:0]      word_idx;
    logic                  out_of_range;
    logic                  enter_ack;
    logic                  ram_rd_en;
    logic                  ram_we;
    logic [BUS_SIZE-1:0]   ram_rdata;
    logic                  addr_offset_unused;

    assign req          = avs_read | avs_write;
    assign word_idx     = avs_address[TOP_LSB-1:OFF_W];
    assign out_of_range = |avs_address[ADDR_W-1:TOP_LSB];

    // Byte offset within a word carries no meaning for a full-word slave.
    assign addr_offset_unused = ^avs_address[OFF_W-1:0];

    assign avs_waitrequest = req & (state_q != ST_ACK);

    // The edge that moves the FSM into ACK is the edge that launches the read.
    always_comb begin
        enter_ack = 1'b0;
        case (state_q)
            ST_IDLE: enter_ack = req && (WAIT_CYCLES == 0);
            ST_WAIT: enter_ack = req && (cnt_q == '0);
            default: enter_ack = 1'b0;
        endcase
    end

    // A simultaneous read+write is a write, so reads are launched only without avs_write.
    assign ram_rd_en = enter_ack && !avs_write && !out_of_range;
    // Gated by reset so a write caught by reset in ACK never lands.
    assign ram_we    = (state_q == ST_ACK) && avs_write && !out_of_range && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            if (enter_ack && !avs_write) begin
                rd_zero_q <= out_of_range;
            end
            if (avs_read && avs_write) begin
                err_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q <= ST_ACK;
                        end else begin
                            cnt_q   <= CNT_LOAD;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req) begin
                        // Master abandoned a stalled request.
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACK: begin
                    if (req && out_of_range) begin
                        err_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    atax_be_ram #(
        .DATA_W (BUS_SIZE),
        .BYTES  (BUS_BYTES),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i     (clk),
        .reset_i   (reset),
        .a_en_i    (ram_rd_en),
        .a_we_i    (ram_we),
        .a_be_i    (avs_byteenable),
        .a_addr_i  (word_idx),
        .a_wdata_i (avs_writedata),
        .a_rdata_o (ram_rdata),
        .b_we_i    (ld_en),
        .b_addr_i  (ld_addr),
        .b_wdata_i (ld_data),
        .b_rdata_o (dump_data)
    );

    assign avs_readdata = rd_zero_q ? '0 : ram_rdata;
    assign err          = err_q;

endmodule

// File: tb/tb_atax_arg_mem.sv
// tb/tb_atax_arg_mem.sv - self-checking bench for atax_arg_mem
module tb_atax_arg_mem;
    import atax_pkg::*;

    localparam int WAITC = 1;
    localparam int LAT   = WAITC + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_address = '0;
    logic [63:0] avs_writedata = '0;
    logic [7:0]  avs_byteenable = '0;
    logic [63:0] avs_readdata;
    logic        avs_waitrequest;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [63:0] ld_data = '0;
    logic [63:0] dump_data;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [63:0] model [256];

    atax_arg_mem #(
        .BUS_SIZE(64), .BUS_BYTES(8), .ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(WAITC)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dump_data(dump_data), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; avs_read = 0; avs_write = 0; ld_en = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic ld_write(input int idx, input logic [63:0] d);
        ld_en = 1'b1; ld_addr = 8'(idx); ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        model[idx] = d;
    endtask

    task automatic dump_word(input int idx, output logic [63:0] d);
        ld_addr = 8'(idx);
        @(posedge clk); #2;
        d = dump_data;
    endtask

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [7:0] be,
                        output logic [63:0] rdata, output int lat);
        avs_read = rd; avs_write = wr; avs_address = addr;
        avs_writedata = wdata; avs_byteenable = be;
        lat = 1; #1;
        while (avs_waitrequest === 1'b1 && lat < 16) begin
            @(posedge clk); #2; lat++;
        end
        rdata = avs_readdata;
        @(posedge clk); #1;
        avs_read = 0; avs_write = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (avs_readdata !== 64'h0) begin errors++; $display("FAIL reset_readdata got %h exp 0", avs_readdata); end
        checks++; if (dump_data !== 64'h0) begin errors++; $display("FAIL reset_dump got %h exp 0", dump_data); end
        checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %b exp 0", avs_waitrequest); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state_q); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_preload();
        logic [63:0] d;
        for (int i = 0; i < 256; i++) ld_write(i, {$urandom, $urandom});
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = $urandom_range(0, 255);
            dump_word(idx, d);
            checks++; if (d !== model[idx]) begin errors++; $display("FAIL preload_dump[%0d] got %h exp %h", idx, d, model[idx]); end
        end
    endtask

    task automatic test_read_latency();
        ld_write(3, 64'h1122334455667788);
        avs_read = 1'b1; avs_address = 32'h18; #1;
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL lat_wr_c1 got %b exp 1", avs_waitrequest); end
        @(posedge clk); #2;
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL lat_wr_c2 got %b exp 1", avs_waitrequest); end
        @(posedge clk); #2;
        checks++; if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL lat_wr_c3 got %b exp 0", avs_waitrequest); end
        checks++; if (avs_readdata !== 64'h1122334455667788) begin errors++; $display("FAIL lat_rdata got %h exp 1122334455667788", avs_readdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lat_err got %b exp 0", err); end
        @(posedge clk); #1;
        avs_read = 1'b0;
    endtask

    task automatic test_byte_write();
        logic [63:0] r, d;
        int lat;
        xfer(1'b0, 1'b1, 32'h18, 64'hFFFFFFFFFFFFFFFF, 8'h0F, r, lat);
        model[3] = merge(model[3], 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        checks++; if (lat != LAT) begin errors++; $display("FAIL bw_latency got %0d exp %0d", lat, LAT); end
        dump_word(3, d);
        checks++; if (d !== 64'h11223344FFFFFFFF) begin errors++; $display("FAIL bw_dump got %h exp 11223344FFFFFFFF", d); end
    endtask

    task automatic test_random();
        logic [63:0] r, d, wd;
        logic [7:0] be;
        int lat, idx;
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0: ld_write(idx, {$urandom, $urandom});
                1: begin
                    wd = {$urandom, $urandom}; be = 8'($urandom);
                    xfer(1'b0, 1'b1, {21'h0, 8'(idx), 3'($urandom)}, wd, be, r, lat);
                    model[idx] = merge(model[idx], wd, be);
                    checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_wr_lat got %0d exp %0d", lat, LAT); end
                end
                default: begin
                    xfer(1'b1, 1'b0, {21'h0, 8'(idx), 3'($urandom)}, '0, '0, r, lat);
                    checks++; if (lat != LAT) begin errors++; $display("FAIL rnd_rd_lat got %0d exp %0d", lat, LAT); end
                    checks++; if (r !== model[idx]) begin errors++; $display("FAIL rnd_rd[%0d] got %h exp %h", idx, r, model[idx]); end
                end
            endcase
            if (n % 5 == 0) begin
                idx = $urandom_range(0, 255);
                dump_word(idx, d);
                checks++; if (d !== model[idx]) begin errors++; $display("FAIL rnd_dump[%0d] got %h exp %h", idx, d, model[idx]); end
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rnd_err got %b exp 0", err); end
    endtask

    task automatic test_collision();
        logic [63:0] d;
        int guard;
        avs_write = 1'b1; avs_address = 32'h38; avs_writedata = 64'hB; avs_byteenable = 8'hFF;
        guard = 0; #1;
        while (avs_waitrequest === 1'b1 && guard < 16) begin @(posedge clk); #2; guard++; end
        ld_en = 1'b1; ld_addr = 8'd7; ld_data = 64'hA;
        @(posedge clk); #1;
        ld_en = 1'b0; avs_write = 1'b0;
        model[7] = 64'hA;
        dump_word(7, d);
        checks++; if (d !== 64'hA) begin errors++; $display("FAIL collide_dump got %h exp a", d); end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] d;
        int guard;
        // reset while in WAIT
        avs_write = 1'b1; avs_address = 32'h28; avs_writedata = ~model[5]; avs_byteenable = 8'hFF;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rstwait_state got %0d exp IDLE", dut.state_q); end
        reset = 1'b0; avs_write = 1'b0;
        dump_word(5, d);
        checks++; if (d !== model[5]) begin errors++; $display("FAIL rstwait_dump got %h exp %h", d, model[5]); end
        // reset in the acceptance cycle
        avs_write = 1'b1; avs_address = 32'h30; avs_writedata = ~model[6];
        guard = 0; #1;
        while (avs_waitrequest === 1'b1 && guard < 16) begin @(posedge clk); #2; guard++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; avs_write = 1'b0;
        dump_word(6, d);
        checks++; if (d !== model[6]) begin errors++; $display("FAIL rstack_dump got %h exp %h", d, model[6]); end
    endtask

    task automatic test_out_of_range();
        logic [63:0] r, d;
        int lat;
        xfer(1'b1, 1'b0, 32'h18, '0, '0, r, lat);
        checks++; if (r !== model[3]) begin errors++; $display("FAIL oor_pre_rd got %h exp %h", r, model[3]); end
        xfer(1'b1, 1'b0, 32'h800, '0, '0, r, lat);
        checks++; if (lat != LAT) begin errors++; $display("FAIL oor_rd_lat got %0d exp %0d", lat, LAT); end
        checks++; if (r !== 64'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", r); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", err); end
        xfer(1'b0, 1'b1, 32'h818, ~model[3], 8'hFF, r, lat);
        dump_word(3, d);
        checks++; if (d !== model[3]) begin errors++; $display("FAIL oor_wr_dump got %h exp %h", d, model[3]); end
        apply_reset();
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got %b exp 0", err); end
    endtask

    task automatic test_drop();
        logic [63:0] d;
        avs_read = 1'b1; avs_address = 32'h18; #1;
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL drop_waitreq got %b exp 1", avs_waitrequest); end
        @(posedge clk); #1;
        avs_read = 1'b0;
        @(posedge clk); #1;
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL drop_state got %0d exp IDLE", dut.state_q); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL drop_err got %b exp 1", err); end
        apply_reset();
        avs_write = 1'b1; avs_address = 32'h20; avs_writedata = ~model[4]; avs_byteenable = 8'hFF;
        @(posedge clk); #1;
        avs_write = 1'b0;
        @(posedge clk); #1;
        dump_word(4, d);
        checks++; if (d !== model[4]) begin errors++; $display("FAIL dropwr_dump got %h exp %h", d, model[4]); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL dropwr_err got %b exp 1", err); end
        apply_reset();
    endtask

    task automatic test_both_high();
        logic [63:0] r, d, wd;
        logic [7:0] be;
        int lat;
        wd = {$urandom, $urandom}; be = 8'($urandom) | 8'h01;
        xfer(1'b1, 1'b1, 32'h48, wd, be, r, lat);
        model[9] = merge(model[9], wd, be);
        checks++; if (lat != LAT) begin errors++; $display("FAIL both_lat got %0d exp %0d", lat, LAT); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL both_err got %b exp 1", err); end
        dump_word(9, d);
        checks++; if (d !== model[9]) begin errors++; $display("FAIL both_dump got %h exp %h", d, model[9]); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_preload();
        test_read_latency();
        test_byte_write();
        test_random();
        test_collision();
        test_reset_mid_write();
        test_out_of_range();
        test_drop();
        test_both_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
